// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8
// Receive end of an 8:1 select-driven bit mux. Each valid beat carries one bit
// of a word on F, tagged by the Sel index that produced it. A frame is the
// in-order sequence Sel = 0..7; once it is complete the rebuilt word appears
// on A with a one-cycle A_valid pulse. Out-of-order selects raise Seq_err and
// frames that stall for MAX_GAP idle cycles raise Gap_err. The receiver
// resynchronises on the next Sel = 0.
//
// Parameters:
//   MAX_GAP  idle cycles tolerated inside a frame (0 disables the gap check)
//   GAP_W    gap counter width, 2**GAP_W must exceed MAX_GAP
//
// Ports:
//   Clk      in   1  clock, rising edge
//   Rst      in   1  synchronous reset, active-high
//   Valid    in   1  a bit beat is present on F/Sel
//   Sel      in   3  index of the bit currently on F
//   F        in   1  serial data bit
//   A        out  8  last completed word, A[i] = F sampled with Sel = i
//   A_valid  out  1  one-cycle pulse, A updated this cycle
//   Seq_err  out  1  one-cycle pulse, Sel out of order inside a frame
//   Gap_err  out  1  one-cycle pulse, frame aborted after MAX_GAP idle cycles
// -----------------------------------------------------------------------------
module tdm_demux8 #(
   parameter int MAX_GAP = 4,
   parameter int GAP_W   = 4
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Valid,
   input  logic [2:0] Sel,
   input  logic       F,
   output logic [7:0] A,
   output logic       A_valid,
   output logic       Seq_err,
   output logic       Gap_err
);

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   localparam bit GAP_EN = (MAX_GAP != 0);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);

   state_t           state_r;
   logic [7:0]       shadow_r;
   logic [2:0]       exp_r;
   logic [GAP_W-1:0] gap_r;
   logic [GAP_W-1:0] gap_inc_s;

   assign gap_inc_s = gap_r + GAP_W'(1'b1);

   // Frame FSM: collects beats into the shadow word and drives all registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r  <= HUNT;
         shadow_r <= 8'd0;
         exp_r    <= 3'd0;
         gap_r    <= {GAP_W{1'b0}};
         A        <= 8'd0;
         A_valid  <= 1'b0;
         Seq_err  <= 1'b0;
         Gap_err  <= 1'b0;
      end else begin
         A_valid <= 1'b0;
         Seq_err <= 1'b0;
         Gap_err <= 1'b0;
         case (state_r)
            HUNT: begin
               // Only a Sel = 0 beat can open a frame; anything else is noise.
               if (Valid && (Sel == 3'd0)) begin
                  shadow_r[0] <= F;
                  exp_r       <= 3'd1;
                  gap_r       <= {GAP_W{1'b0}};
                  state_r     <= COLLECT;
               end
            end
            COLLECT: begin
               if (Valid) begin
                  if (Sel == exp_r) begin
                     shadow_r[exp_r] <= F;
                     gap_r           <= {GAP_W{1'b0}};
                     if (exp_r == 3'd7) begin
                        // Last bit goes straight to A; exp wraps to 0 so the
                        // next frame may follow without an idle cycle.
                        A       <= {F, shadow_r[6:0]};
                        A_valid <= 1'b1;
                        exp_r   <= 3'd0;
                     end else begin
                        exp_r <= exp_r + 3'd1;
                     end
                  end else begin
                     Seq_err <= 1'b1;
                     if (Sel == 3'd0) begin
                        // An early Sel = 0 restarts the frame in place; every
                        // older shadow bit is rewritten before it reaches A.
                        shadow_r[0] <= F;
                        exp_r       <= 3'd1;
                        gap_r       <= {GAP_W{1'b0}};
                     end else begin
                        exp_r   <= 3'd0;
                        gap_r   <= {GAP_W{1'b0}};
                        state_r <= HUNT;
                     end
                  end
               end else begin
                  // Idle time only counts inside a frame (exp != 0).
                  if (GAP_EN && (exp_r != 3'd0)) begin
                     if (gap_inc_s == GAP_LIMIT) begin
                        Gap_err <= 1'b1;
                        exp_r   <= 3'd0;
                        gap_r   <= {GAP_W{1'b0}};
                        state_r <= HUNT;
                     end else begin
                        gap_r <= gap_inc_s;
                     end
                  end
               end
            end
            default: begin
               state_r <= HUNT;
               exp_r   <= 3'd0;
               gap_r   <= {GAP_W{1'b0}};
            end
         endcase
      end
   end

   tdm_demux8_checker #(
      .MAX_GAP (MAX_GAP),
      .GAP_W   (GAP_W)
   ) u_checker (
      .clk     (Clk),
      .rst     (Rst),
      .hunt    (state_r == HUNT),
      .exp     (exp_r),
      .gap     (gap_r),
      .a_valid (A_valid),
      .seq_err (Seq_err),
      .gap_err (Gap_err)
   );

endmodule

// -----------------------------------------------------------------------------
// tdm_demux8_checker
// Invariants of the receiver: the three output pulses are mutually exclusive,
// HUNT carries no frame progress, and the gap counter stays below MAX_GAP.
//
// Ports:
//   clk, rst                     clock and synchronous reset
//   hunt                         receiver is in HUNT
//   exp, gap                     expected index and gap counter
//   a_valid, seq_err, gap_err    output pulses
// -----------------------------------------------------------------------------
module tdm_demux8_checker #(
   parameter int MAX_GAP = 4,
   parameter int GAP_W   = 4
) (
   input logic             clk,
   input logic             rst,
   input logic             hunt,
   input logic [2:0]       exp,
   input logic [GAP_W-1:0] gap,
   input logic             a_valid,
   input logic             seq_err,
   input logic             gap_err
);

   pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
      $onehot0({a_valid, seq_err, gap_err}))
      else $error("tdm_demux8: more than one output pulse high");

   hunt_idle: assert property (@(posedge clk) disable iff (rst)
      hunt |-> ((exp == 3'd0) && (gap == {GAP_W{1'b0}})))
      else $error("tdm_demux8: frame progress held while hunting");

   gap_bounded: assert property (@(posedge clk) disable iff (rst)
      (MAX_GAP == 0) || (int'(gap) < MAX_GAP))
      else $error("tdm_demux8: gap counter reached its limit");

endmodule
